mem_bus_arbiter: RTL

- Shares one single-port data RAM (1-cycle registered read, byte-write strobes) between two requesters.
- Requester m0 is the core load/store port; m1 is the program loader / debug port.
- Grants one access per cycle using round-robin with an optional lock.
- Returns read data to the requester that issued the read.
- Sits between the core/loader and the memory in the SoC top.

---
 rtl/mem_bus_arbiter_pkg.sv | 12 +
 rtl/mem_bus_arbiter_rr_pick2.sv | 15 +
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared bus widths, master ids and arbiter state encoding
package bus_defs;
   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOCK0 = 2'd1;
   localparam logic [1:0] ST_LOCK1 = 2'd2;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rtl/mem_bus_arbiter_rr_pick2.sv - two-way round-robin picker with one-hot grant
module rr_pick2 (
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_last,
   output logic [1:0] o_gnt
);
   always_comb begin
      o_gnt = {i_req1, i_req0};
      // On a tie the master that was not served last wins.
      if (i_req0 && i_req1) begin
         o_gnt = i_last ? 2'b01 : 2'b10;
      end
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master single-port RAM arbiter with lock and read return routing
import bus_defs::*;

module mem_bus_arbiter #(
   parameter int ADDR_W   = BUS_ADDR_W,
   parameter int DATA_W   = BUS_DATA_W,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [3:0]        m0_wstrb,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [3:0]        m1_wstrb,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s_en,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [3:0]        s_wstrb,
   input  logic [DATA_W-1:0] s_rdata
);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       r_state;
   logic             r_last;
   logic [CNT_W-1:0] r_lock_cnt;
   logic             r_pend_v;
   logic             r_pend_id;
   logic             r_hold;

   logic [1:0]       w_pick;
   logic [1:0]       w_gnt;
   logic             w_active;
   logic             w_any;
   logic             w_sel;
   logic             w_sel_we;
   logic             w_sel_lock;
   logic             w_own_lock;
   logic             w_ret;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [1:0]       w_state_nxt;
   logic             w_last_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   rr_pick2 u_pick (
      .i_req0 (m0_req),
      .i_req1 (m1_req),
      .i_last (r_last),
      .o_gnt  (w_pick)
   );

   // No grants while reset is asserted nor in the first cycle after it.
   assign w_active = rst && !r_hold;

   always_comb begin
      w_gnt = w_pick;
      case (r_state)
         ST_LOCK0: w_gnt = m0_req ? 2'b01 : {m1_req, 1'b0};
         ST_LOCK1: w_gnt = m1_req ? 2'b10 : {1'b0, m0_req};
         default:  w_gnt = w_pick;
      endcase
      if (!w_active) begin
         w_gnt = 2'b00;
      end
   end

   assign m0_gnt     = w_gnt[0];
   assign m1_gnt     = w_gnt[1];
   assign w_any      = |w_gnt;
   assign w_sel      = w_gnt[1] ? M1 : M0;
   assign w_sel_we   = (w_sel == M1) ? m1_we : m0_we;
   assign w_sel_lock = (w_sel == M1) ? m1_lock : m0_lock;
   assign w_own_lock = (w_sel == M1) ? (r_state == ST_LOCK1) : (r_state == ST_LOCK0);
   assign w_cnt_inc  = r_lock_cnt + CNT_ONE;

   assign s_en    = w_any;
   assign s_we    = w_any && w_sel_we;
   assign s_addr  = !w_any ? '0 : ((w_sel == M1) ? m1_addr : m0_addr);
   assign s_wdata = !w_any ? '0 : ((w_sel == M1) ? m1_wdata : m0_wdata);
   assign s_wstrb = !(w_any && w_sel_we) ? 4'h0 : ((w_sel == M1) ? m1_wstrb : m0_wstrb);

   // Lock falls back to IDLE on lock release, idle holder, or when the cap is reached.
   always_comb begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_last_nxt  = r_last;
      if (w_any) begin
         w_last_nxt = w_sel;
         if (w_own_lock) begin
            if (w_sel_lock && (w_cnt_inc < CNT_MAX)) begin
               w_state_nxt = r_state;
               w_cnt_nxt   = w_cnt_inc;
            end
         end else if (w_sel_lock && (LOCK_MAX > 1)) begin
            w_state_nxt = (w_sel == M1) ? ST_LOCK1 : ST_LOCK0;
            w_cnt_nxt   = CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_last     <= M1;
         r_lock_cnt <= '0;
         r_pend_v   <= 1'b0;
         r_pend_id  <= M0;
         r_hold     <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_last     <= w_last_nxt;
         r_lock_cnt <= w_cnt_nxt;
         r_pend_v   <= w_any && !w_sel_we;
         r_pend_id  <= w_sel;
         r_hold     <= 1'b0;
      end
   end

   assign w_ret     = r_pend_v && rst;
   assign m0_rvalid = w_ret && (r_pend_id == M0);
   assign m1_rvalid = w_ret && (r_pend_id == M1);
   assign m0_rdata  = m0_rvalid ? s_rdata : '0;
   assign m1_rdata  = m1_rvalid ? s_rdata : '0;
endmodule
